db_client: RTL and testbench

DB_CLIENT -- requirements
Module: db_client

---
 rtl/db_client.sv | 207 ++++++++++++++++++++
 tb/tb_db_client.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/db_client.sv
// db_client: issues lookup requests to the DB, tracks outstanding packet tags
// in order, and returns one response per request, either with the DB result
// or by timeout. DB responses that belong to timed-out requests are dropped,
// and a response that arrives with nothing outstanding raises err_orphan.
module db_client #(
  parameter int KEY_SIZE   = 96,
  parameter int FLAG_SIZE  = 4,
  parameter int TAG_SIZE   = 8,
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEY_SIZE-1:0]  req_key,
  input  logic [FLAG_SIZE-1:0] req_flag,
  input  logic [TAG_SIZE-1:0]  req_tag,
  output logic [KEY_SIZE-1:0]  in_key,
  output logic [FLAG_SIZE-1:0] in_flag,
  output logic                 in_valid,
  input  logic                 out_valid,
  input  logic [FLAG_SIZE-1:0] out_flag,
  output logic                 rsp_valid,
  output logic [TAG_SIZE-1:0]  rsp_tag,
  output logic [FLAG_SIZE-1:0] rsp_flag,
  output logic                 rsp_timeout,
  output logic                 err_orphan
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]     WAIT_ZERO = {WAIT_W{1'b0}};

  // Tag FIFO storage and bookkeeping
  logic [TAG_SIZE-1:0]   r_tag_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [WAIT_W-1:0]     r_wait;
  logic [7:0]            r_stale;

  // Registered outputs
  logic                  r_in_valid;
  logic [KEY_SIZE-1:0]   r_in_key;
  logic [FLAG_SIZE-1:0]  r_in_flag;
  logic                  r_rsp_valid;
  logic [TAG_SIZE-1:0]   r_rsp_tag;
  logic [FLAG_SIZE-1:0]  r_rsp_flag;
  logic                  r_rsp_timeout;
  logic                  r_err_orphan;

  // Decoded per-cycle events
  logic w_full;
  logic w_empty;
  logic w_stale_zero;
  logic w_db_pop;
  logic w_stale_drop;
  logic w_orphan;
  logic w_to_pop;
  logic w_pop;
  logic w_push;

  // Decode this cycle's DB response, timeout and acceptance events
  always_comb begin
    w_full       = 1'b0;
    w_empty      = 1'b0;
    w_stale_zero = 1'b0;
    w_db_pop     = 1'b0;
    w_stale_drop = 1'b0;
    w_orphan     = 1'b0;
    w_to_pop     = 1'b0;
    w_pop        = 1'b0;
    w_push       = 1'b0;

    w_full       = (r_count == CNT_FULL);
    w_empty      = (r_count == CNT_ZERO);
    w_stale_zero = (r_stale == 8'd0);

    // A DB response either completes the head, pays off a stale debt, or is an orphan
    if (out_valid) begin
      w_db_pop     = w_stale_zero && !w_empty;
      w_stale_drop = !w_stale_zero;
      w_orphan     = w_stale_zero && w_empty;
    end else begin
      w_db_pop     = 1'b0;
      w_stale_drop = 1'b0;
      w_orphan     = 1'b0;
    end

    // The DB result wins over a timeout landing on the same cycle
    if (!w_empty && !w_db_pop && (r_wait == WAIT_LAST)) begin
      w_to_pop = 1'b1;
    end else begin
      w_to_pop = 1'b0;
    end

    w_pop  = w_db_pop || w_to_pop;
    // A full FIFO may still take a request when the head leaves on the same cycle
    w_push = req_valid && (!w_full || w_pop);
  end

  assign req_ready = !w_full;

  // Tag FIFO: storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag_mem[i] <= {TAG_SIZE{1'b0}};
      end
      r_wr_ptr <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr <= {DEPTH_LOG2{1'b0}};
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr] <= req_tag;
        r_wr_ptr            <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head wait timer: restarts on every pop and idles at zero while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= WAIT_ZERO;
    end else if (w_pop || w_empty) begin
      r_wait <= WAIT_ZERO;
    end else begin
      r_wait <= r_wait + WAIT_ONE;
    end
  end

  // Stale counter: DB responses still owed for requests already timed out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stale <= 8'd0;
    end else begin
      case ({w_to_pop, w_stale_drop})
        2'b10:   r_stale <= (r_stale == 8'hFF) ? r_stale : r_stale + 8'd1;
        2'b01:   r_stale <= r_stale - 8'd1;
        default: r_stale <= r_stale;
      endcase
    end
  end

  // DB request side: one-cycle strobe, key and flag hold between requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_valid <= 1'b0;
      r_in_key   <= {KEY_SIZE{1'b0}};
      r_in_flag  <= {FLAG_SIZE{1'b0}};
    end else begin
      r_in_valid <= w_push;
      if (w_push) begin
        r_in_key  <= req_key;
        r_in_flag <= req_flag;
      end
    end
  end

  // Response side: one-cycle strobe with the head tag, plus sticky orphan error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_tag     <= {TAG_SIZE{1'b0}};
      r_rsp_flag    <= {FLAG_SIZE{1'b0}};
      r_rsp_timeout <= 1'b0;
      r_err_orphan  <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop;
      if (w_pop) begin
        r_rsp_tag     <= r_tag_mem[r_rd_ptr];
        r_rsp_flag    <= w_db_pop ? out_flag : {FLAG_SIZE{1'b0}};
        r_rsp_timeout <= w_to_pop;
      end
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign in_valid    = r_in_valid;
  assign in_key      = r_in_key;
  assign in_flag     = r_in_flag;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_tag     = r_rsp_tag;
  assign rsp_flag    = r_rsp_flag;
  assign rsp_timeout = r_rsp_timeout;
  assign err_orphan  = r_err_orphan;

endmodule

// File: tb/tb_db_client.sv
// Testbench for db_client: directed scenarios plus a randomized phase, all
// checked against a transaction-level model (tag queue, stale debt, head age).
module tb_db_client;

  localparam int KS  = 96;
  localparam int FS  = 4;
  localparam int TS  = 8;
  localparam int TO  = 1024;
  localparam int DEP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [KS-1:0] req_key = '0;
  logic [FS-1:0] req_flag = '0;
  logic [TS-1:0] req_tag = '0;
  logic [KS-1:0] in_key;
  logic [FS-1:0] in_flag;
  logic          in_valid;
  logic          out_valid = 1'b0;
  logic [FS-1:0] out_flag = '0;
  logic          rsp_valid;
  logic [TS-1:0] rsp_tag;
  logic [FS-1:0] rsp_flag;
  logic          rsp_timeout;
  logic          err_orphan;

  db_client dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_flag(req_flag), .req_tag(req_tag),
    .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
    .out_valid(out_valid), .out_flag(out_flag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_flag(rsp_flag),
    .rsp_timeout(rsp_timeout), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [TS-1:0] m_q[$];
  int            m_stale;
  int            m_age;
  bit            m_orphan;
  logic [KS-1:0] m_in_key;
  logic [FS-1:0] m_in_flag;
  int            db_due;
  bit            seen_to;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_stale   = 0;
    m_age     = 0;
    m_orphan  = 1'b0;
    m_in_key  = '0;
    m_in_flag = '0;
  endtask

  // One clock: drive inputs, predict, clock, compare
  task automatic step(input logic rv, input logic [KS-1:0] k, input logic [FS-1:0] f,
                      input logic [TS-1:0] t, input logic ov, input logic [FS-1:0] of);
    bit full, empty, dbp, drop, orph, top, pop, push;
    logic [TS-1:0] head;
    req_valid = rv; req_key = k; req_flag = f; req_tag = t;
    out_valid = ov; out_flag = of;
    #1;
    full  = (m_q.size() == DEP);
    empty = (m_q.size() == 0);
    chk("req_ready", req_ready, !full);
    head = empty ? '0 : m_q[0];
    dbp  = ov && (m_stale == 0) && !empty;
    drop = ov && (m_stale != 0);
    orph = ov && (m_stale == 0) && empty;
    top  = !dbp && !empty && (m_age == TO - 1);
    pop  = dbp || top;
    push = rv && (!full || pop);
    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      m_q.push_back(t);
      m_in_key  = k;
      m_in_flag = f;
    end
    m_age = (pop || empty) ? 0 : m_age + 1;
    if (top && !drop && m_stale < 255) m_stale++;
    else if (drop && !top) m_stale--;
    if (orph) m_orphan = 1'b1;
    chk("in_valid", in_valid, push);
    chk("in_key", in_key, m_in_key);
    chk("in_flag", in_flag, m_in_flag);
    chk("rsp_valid", rsp_valid, pop);
    if (pop) begin
      chk("rsp_tag", rsp_tag, head);
      chk("rsp_flag", rsp_flag, dbp ? of : 4'h0);
      chk("rsp_timeout", rsp_timeout, top);
    end
    chk("err_orphan", err_orphan, m_orphan);
    if (rsp_valid && rsp_timeout) seen_to = 1'b1;
    if (in_valid) db_due++;
    if (ov) db_due--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_valid"}, in_valid, 1'b0);
    chk({tag, "_in_key"}, in_key, '0);
    chk({tag, "_in_flag"}, in_flag, '0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_tag"}, rsp_tag, '0);
    chk({tag, "_rsp_flag"}, rsp_flag, '0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    chk({tag, "_err_orphan"}, err_orphan, 1'b0);
  endtask

  // Asynchronous reset pulse applied away from the clock edge
  task automatic do_reset();
    req_valid = 1'b0; out_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("rst");
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    #1;
    model_clear();
    db_due = 0;
    chk("rst_req_ready", req_ready, 1'b1);
  endtask

  function automatic logic [KS-1:0] rkey();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    model_clear();
    db_due  = 0;
    seen_to = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request, DB answers three cycles after acceptance
    step(1'b1, 96'h1, 4'h1, 8'h05, 1'b0, 4'h0);
    idle(2);
    step(1'b0, '0, '0, '0, 1'b1, 4'h2);
    idle(1);

    // Fill all eight entries, then drain in order
    for (int i = 0; i < DEP; i++) step(1'b1, rkey(), 4'(i), 8'(i), 1'b0, 4'h0);
    step(1'b1, rkey(), 4'h9, 8'h99, 1'b0, 4'h0);  // refused: full, no pop
    for (int i = 0; i < DEP; i++) step(1'b0, '0, '0, '0, 1'b1, 4'($urandom_range(1, 15)));
    idle(2);

    // Timeout, then the late DB response is swallowed
    seen_to = 1'b0;
    step(1'b1, rkey(), 4'h3, 8'h3C, 1'b0, 4'h0);
    for (int i = 0; i < TO + 4 && !seen_to; i++) idle(1);
    chk("timeout_seen", seen_to, 1'b1);
    idle(3);
    step(1'b0, '0, '0, '0, 1'b1, 4'h7);  // stale response: no rsp_valid
    step(1'b1, rkey(), 4'h4, 8'h44, 1'b0, 4'h0);
    idle(1);
    step(1'b0, '0, '0, '0, 1'b1, 4'h6);  // stale cleared: this one completes
    idle(1);

    // Full FIFO with simultaneous response and new request
    for (int i = 0; i < DEP; i++) step(1'b1, rkey(), 4'h5, 8'(8'h80 + i), 1'b0, 4'h0);
    step(1'b1, rkey(), 4'hA, 8'hA0, 1'b1, 4'hB);
    step(1'b0, '0, '0, '0, 1'b0, 4'h0);  // req_ready still low: occupancy 8
    for (int i = 0; i < DEP; i++) step(1'b0, '0, '0, '0, 1'b1, 4'($urandom_range(0, 15)));
    idle(1);

    // Orphan response on an empty FIFO is sticky
    step(1'b0, '0, '0, '0, 1'b1, 4'hF);
    idle(5);

    // Reset with three outstanding: responses afterwards are orphans
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, rkey(), 4'h2, 8'(8'h30 + i), 1'b0, 4'h0);
    idle(1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 4'h9);
    idle(2);

    // Randomized traffic with a well-behaved DB
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic rv, ov;
      rv = ($urandom_range(0, 99) < 60);
      ov = (db_due > 0) && ($urandom_range(0, 99) < 45);
      step(rv, rkey(), 4'($urandom), 8'($urandom), ov, 4'($urandom));
    end
    while (db_due > 0) step(1'b0, '0, '0, '0, 1'b1, 4'($urandom));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
